rr_burst_arbiter: RTL and testbench

//  - Round-robin arbiter sharing one downstream resource among REQS requesters, with burst hold.
//  - Winner keeps the grant across a multi-beat burst until one of these occurs:
//    its last beat, MAX_BURST beats, or it drops req.
//  - Sits between requester ports and the shared datapath. gnt_id_o drives the datapath mux select.

---
 rtl/rr_burst_arbiter_pkg.sv | 12 +
 rtl/rr_burst_arbiter_pick.sv | 29 ++
 rtl/rr_burst_arbiter.sv | 113 +++++++++++
 tb/tb_rr_burst_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int unsigned ARB_MAX_REQS = 32;

    function automatic logic [ARB_MAX_REQS-1:0] onehot_from_idx(input int unsigned idx);
        return {{(ARB_MAX_REQS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational rotate-priority picker: first eligible request after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned REQS = 4,
    localparam int unsigned IDW  = $clog2(REQS)
) (
    input  logic [REQS-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic [REQS-1:0] mask,
    output logic            found,
    output logic [IDW-1:0]  idx
);

    int unsigned k;

    // Scan from farthest to nearest so the nearest eligible slot is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int unsigned i = REQS; i >= 1; i--) begin
            k = (32'(ptr) + i) % REQS;
            if (req[k] && !mask[k]) begin
                found = 1'b1;
                idx   = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with burst hold; gnt_id_o steers the shared datapath mux.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned REQS      = 4,
    parameter  int unsigned MAX_BURST = 8,
    localparam int unsigned IDW       = $clog2(REQS),
    localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REQS-1:0] req_i,
    input  logic [REQS-1:0] last_i,
    input  logic            ready_i,
    output logic [REQS-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            busy_o
);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [REQS-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            busy_q, busy_d;

    logic            beat, rel_mask, rel_max, rel_w;
    logic [IDW-1:0]  pick_ptr, pick_idx;
    logic [REQS-1:0] pick_mask, pick_oh, win_oh;
    logic            pick_found;

    assign beat     = busy_q & req_i[gnt_id_q] & ready_i;
    assign rel_mask = busy_q & (~req_i[gnt_id_q] | (beat & last_i[gnt_id_q]));
    assign rel_max  = beat & (cnt_q == CW'(MAX_BURST - 1));
    assign rel_w    = (state_q == ARB_GRANT) & (rel_mask | rel_max);

    assign win_oh  = REQS'(onehot_from_idx(32'(gnt_id_q)));
    assign pick_oh = REQS'(onehot_from_idx(32'(pick_idx)));

    // During a grant the winner acts as the pointer; it stays eligible only after a max-burst release.
    assign pick_ptr  = (state_q == ARB_GRANT) ? gnt_id_q : ptr_q;
    assign pick_mask = (state_q == ARB_GRANT && rel_mask) ? win_oh : '0;

    rr_pick #(.REQS(REQS)) u_pick (
        .req   (req_i),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= IDW'(REQS - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                if (rel_w) begin
                    ptr_d   = gnt_id_q;
                    cnt_d   = '0;
                    state_d = pick_found ? ARB_GRANT : ARB_IDLE;
                end else if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        if (state_d == ARB_IDLE) begin
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
        end else if (state_q == ARB_IDLE || rel_w) begin
            gnt_d    = pick_oh;
            gnt_id_d = pick_idx;
            busy_d   = 1'b1;
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench: two arbiters (MAX_BURST 8 and 1) share stimulus and are checked against a grant-owner model.
module tb_rr_burst_arbiter;

    localparam int REQS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, last;
    logic       ready;
    logic [3:0] gnt8, gnt1;
    logic [1:0] id8, id1;
    logic       busy8, busy1;

    always #5 clk = ~clk;

    rr_burst_arbiter #(.REQS(4), .MAX_BURST(8)) dut8 (
        .clk(clk), .reset(reset), .req_i(req), .last_i(last), .ready_i(ready),
        .gnt_o(gnt8), .gnt_id_o(id8), .busy_o(busy8)
    );

    rr_burst_arbiter #(.REQS(4), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .req_i(req), .last_i(last), .ready_i(ready),
        .gnt_o(gnt1), .gnt_id_o(id1), .busy_o(busy1)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    // Model: who owns the resource (-1 = nobody), beats taken so far, last winner.
    int owner[2];
    int cnt[2];
    int ptr[2];
    int maxb[2] = '{8, 1};
    int passed = 0;
    int total  = 0;
    int resets_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act === req_v) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    endtask

    function automatic int pick(input logic [3:0] r, input int after, input int excl);
        for (int i = 1; i <= REQS; i++) begin
            int k;
            k = (after + i) % REQS;
            if (r[k] && k != excl) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1;
            cnt[m]   = 0;
            ptr[m]   = REQS - 1;
        end
    endtask

    task automatic model_step(input int m);
        int  o, excl;
        bit  rel, bt;
        if (owner[m] < 0) begin
            owner[m] = pick(req, ptr[m], -1);
            cnt[m]   = 0;
        end else begin
            o    = owner[m];
            rel  = 0;
            excl = -1;
            bt   = req[o] && ready;
            if (!req[o]) begin
                rel = 1; excl = o;
            end else if (bt && last[o]) begin
                rel = 1; excl = o;
            end else if (bt && cnt[m] == maxb[m] - 1) begin
                rel = 1;
            end else if (bt) begin
                cnt[m]++;
            end
            if (rel) begin
                ptr[m]   = o;
                cnt[m]   = 0;
                owner[m] = pick(req, o, excl);
            end
        end
    endtask

    function automatic exp_t expect_of(input int m);
        exp_t e;
        e.busy = owner[m] >= 0;
        e.gnt  = (owner[m] >= 0) ? 4'(1 << owner[m]) : 4'b0;
        e.id   = (owner[m] >= 0) ? 2'(owner[m]) : 2'b0;
        return e;
    endfunction

    task automatic push_both();
        q8.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rd);
        @(negedge clk);
        req = r; last = l; ready = rd;
        model_step(0);
        model_step(1);
        push_both();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_async_gnt8", 32'(gnt8), 0);
        check("rst_async_busy8", 32'(busy8), 0);
        check("rst_async_gnt1", 32'(gnt1), 0);
        check("rst_async_busy1", 32'(busy1), 0);
        model_reset();
        push_both();
        @(negedge clk);
        reset = 1'b0;
        req = '0; last = '0; ready = 1'b0;
        model_step(0);
        model_step(1);
        push_both();
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check("gnt8", 32'(gnt8), 32'(e.gnt));
            check("busy8", 32'(busy8), 32'(e.busy));
            if (e.busy) check("id8", 32'(id8), 32'(e.id));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("gnt1", 32'(gnt1), 32'(e.gnt));
            check("busy1", 32'(busy1), 32'(e.busy));
            if (e.busy) check("id1", 32'(id1), 32'(e.id));
        end
    end

    initial begin
        logic [3:0] r;
        reset = 1'b1;
        req = '0; last = '0; ready = 1'b0;
        #1;
        check("reset_gnt", 32'(gnt8), 0);
        check("reset_id", 32'(id8), 0);
        check("reset_busy", 32'(busy8), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_step(0);
        model_step(1);
        push_both();

        // First grant after reset goes to the lowest set bit.
        drive(4'b1010, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);

        // Requester 2 alone, last on the third beat, then full contention.
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0100, 4'b0100, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 40; i++) drive(4'b1111, 4'b0000, 1'b1);

        // Requester 1 stalled by ready, then abandons.
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) drive(4'b0010, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) drive(4'b1101, 4'b0000, 1'b0);

        // Two requesters with toggling ready.
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) drive(4'b0011, 4'b0000, (i % 2) == 0);

        // Reset in the middle of a burst with four beats taken.
        drive(4'b0000, 4'b0000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) drive(4'b1000, 4'b0000, 1'b1);
        check("model_cnt_before_reset", 32'(cnt[0]), 4);
        do_reset();
        for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0000, 1'b1);

        // Random traffic; requests mostly held, occasional mid-burst resets.
        r = 4'b0000;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < REQS; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            if (resets_done < 3 && owner[0] >= 0 && cnt[0] == 4 && $urandom_range(0, 1) == 0) begin
                resets_done++;
                do_reset();
            end else begin
                drive(r, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                      $urandom_range(0, 3) != 0);
            end
        end

        @(posedge clk);
        #2;
        check("drain8", 32'(q8.size()), 0);
        check("drain1", 32'(q1.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
